// File: rtl/memory_arbiter_pkg.sv
// Shared core types for the memory arbiter: request record, line width, FSM states, requester ids.
package memory_arbiter_pkg;

    localparam int ICACHE_LINE_WIDTH = 64;
    localparam int ADDR_WIDTH        = 32;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0]        addr;
        logic                         is_store;
        logic [ICACHE_LINE_WIDTH-1:0] wdata;
    } memory_request_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REQ      = 2'd1,
        WAIT_RSP = 2'd2
    } arb_state_t;

    typedef enum logic {
        ICACHE = 1'b0,
        DCACHE = 1'b1
    } requester_t;

endpackage

// File: rtl/memory_arbiter_if.sv
// Cache-side and memory-side handshake bundle of the memory arbiter.
// slave: the arbiter itself; master: the surrounding caches and memory model.
interface memory_arbiter_if;
    import memory_arbiter_pkg::*;

    logic                         ic_req_valid;
    memory_request_t              ic_req_info;
    logic                         dc_req_valid;
    memory_request_t              dc_req_info;
    logic                         ic_rsp_valid;
    logic [ICACHE_LINE_WIDTH-1:0] ic_rsp_data;
    logic                         dc_rsp_valid;
    logic [ICACHE_LINE_WIDTH-1:0] dc_rsp_data;
    logic                         mem_req_valid;
    memory_request_t              mem_req_info;
    logic                         mem_req_ready;
    logic                         mem_rsp_valid;
    logic [ICACHE_LINE_WIDTH-1:0] mem_rsp_data;
    logic                         arb_busy;

    modport slave (
        input  ic_req_valid, ic_req_info, dc_req_valid, dc_req_info,
        input  mem_req_ready, mem_rsp_valid, mem_rsp_data,
        output ic_rsp_valid, ic_rsp_data, dc_rsp_valid, dc_rsp_data,
        output mem_req_valid, mem_req_info, arb_busy
    );

    modport master (
        output ic_req_valid, ic_req_info, dc_req_valid, dc_req_info,
        output mem_req_ready, mem_rsp_valid, mem_rsp_data,
        input  ic_rsp_valid, ic_rsp_data, dc_rsp_valid, dc_rsp_data,
        input  mem_req_valid, mem_req_info, arb_busy
    );

endinterface

// File: rtl/memory_arbiter_rr_select.sv
// Two-way grant picker: a lone request wins; a tie goes to whoever was not granted last.
// Latency: combinational.
// Backpressure: none, the caller decides when the grant is consumed.
module arb_rr_select
    import memory_arbiter_pkg::*;
(
    input  logic       req_ic,
    input  logic       req_dc,
    input  requester_t last_grant,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        if (req_ic && req_dc) begin
            grant = (last_grant == DCACHE) ? 2'b01 : 2'b10;
        end else if (req_ic) begin
            grant = 2'b01;
        end else if (req_dc) begin
            grant = 2'b10;
        end
    end

endmodule

// File: rtl/memory_arbiter.sv
// Arbitrates icache/dcache misses onto one main-memory port; optional ARB_ROUND_ROBIN_EN tie policy.
// Latency: grant 1 cycle after request, response 1 cycle after mem_rsp_valid.
// Backpressure: mem_req_valid held with stable info until mem_req_ready; one transaction in flight.
module memory_arbiter
    import memory_arbiter_pkg::*;
(
    input logic             clock,
    input logic             reset,
    memory_arbiter_if.slave bus
);

    arb_state_t      state;
    arb_state_t      state_nxt;
    requester_t      owner;
    requester_t      last_grant;
    logic            ic_pend;
    logic            dc_pend;
    memory_request_t ic_buf;
    memory_request_t dc_buf;
    memory_request_t req_info;
    logic            ic_rsp_vld;
    logic            dc_rsp_vld;
    logic [ICACHE_LINE_WIDTH-1:0] ic_rsp_dat;
    logic [ICACHE_LINE_WIDTH-1:0] dc_rsp_dat;

    logic            do_grant;
    logic            mem_req_vld;
    logic            rsp_done;
    logic [1:0]      grant;

    // A pulse is only taken when its requester has nothing queued or in flight.
    logic ic_owning, dc_owning, ic_drop, dc_drop, ic_take, dc_take;
    logic ic_vis, dc_vis, ic_win, dc_win;
    memory_request_t ic_info_sel, dc_info_sel;

    assign ic_owning   = (state != IDLE) && (owner == ICACHE);
    assign dc_owning   = (state != IDLE) && (owner == DCACHE);
    assign ic_drop     = bus.ic_req_valid && (ic_pend || ic_owning);
    assign dc_drop     = bus.dc_req_valid && (dc_pend || dc_owning);
    assign ic_take     = bus.ic_req_valid && !ic_drop;
    assign dc_take     = bus.dc_req_valid && !dc_drop;
    assign ic_vis      = ic_pend || ic_take;
    assign dc_vis      = dc_pend || dc_take;
    assign ic_info_sel = ic_pend ? ic_buf : bus.ic_req_info;
    assign dc_info_sel = dc_pend ? dc_buf : bus.dc_req_info;
    assign ic_win      = do_grant && grant[0];
    assign dc_win      = do_grant && grant[1];

    arb_rr_select u_select (
        .req_ic     (ic_vis),
        .req_dc     (dc_vis),
        .last_grant (last_grant),
        .grant      (grant)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        do_grant    = 1'b0;
        mem_req_vld = 1'b0;
        rsp_done    = 1'b0;
        case (state)
            IDLE: begin
                if (ic_vis || dc_vis) begin
                    do_grant  = 1'b1;
                    state_nxt = REQ;
                end
            end
            REQ: begin
                mem_req_vld = 1'b1;
                if (bus.mem_req_ready) begin
                    state_nxt = WAIT_RSP;
                end
            end
            WAIT_RSP: begin
                if (bus.mem_rsp_valid) begin
                    rsp_done  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

`ifdef ARB_ROUND_ROBIN_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            last_grant <= ICACHE;
        end else if (do_grant) begin
            last_grant <= grant[1] ? DCACHE : ICACHE;
        end
    end
`else
    // Pinning "icache granted last" makes every tie resolve to the dcache.
    assign last_grant = ICACHE;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ic_pend    <= 1'b0;
            dc_pend    <= 1'b0;
            ic_buf     <= '0;
            dc_buf     <= '0;
            req_info   <= '0;
            owner      <= ICACHE;
            ic_rsp_vld <= 1'b0;
            dc_rsp_vld <= 1'b0;
            ic_rsp_dat <= '0;
            dc_rsp_dat <= '0;
        end else begin
            ic_pend <= ic_vis && !ic_win;
            dc_pend <= dc_vis && !dc_win;
            if (ic_take) begin
                ic_buf <= bus.ic_req_info;
            end
            if (dc_take) begin
                dc_buf <= bus.dc_req_info;
            end
            if (do_grant) begin
                req_info <= grant[1] ? dc_info_sel : ic_info_sel;
                owner    <= grant[1] ? DCACHE : ICACHE;
            end
            ic_rsp_vld <= rsp_done && (owner == ICACHE);
            dc_rsp_vld <= rsp_done && (owner == DCACHE);
            if (rsp_done && (owner == ICACHE)) begin
                ic_rsp_dat <= bus.mem_rsp_data;
            end
            if (rsp_done && (owner == DCACHE)) begin
                dc_rsp_dat <= bus.mem_rsp_data;
            end
        end
    end

    assign bus.mem_req_valid = mem_req_vld;
    assign bus.mem_req_info  = req_info;
    assign bus.arb_busy      = (state != IDLE);
    assign bus.ic_rsp_valid  = ic_rsp_vld;
    assign bus.ic_rsp_data   = ic_rsp_dat;
    assign bus.dc_rsp_valid  = dc_rsp_vld;
    assign bus.dc_rsp_data   = dc_rsp_dat;

    ic_no_drop_a: assert property (@(posedge clock) disable iff (reset) !ic_drop);
    dc_no_drop_a: assert property (@(posedge clock) disable iff (reset) !dc_drop);

endmodule

// File: tb/tb_memory_arbiter.sv
// Self-checking bench for memory_arbiter: directed vector table, corner sequences, random traffic vs a model.
module tb_memory_arbiter;
    import memory_arbiter_pkg::*;

`ifdef ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif
    localparam logic [63:0] LINE_A5 = 64'hA5A5_A5A5_A5A5_A5A5;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    memory_arbiter_if bus ();

    memory_arbiter dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        ic_v;
        logic        dc_v;
        logic [31:0] ic_addr;
        logic [31:0] dc_addr;
        logic        dc_store;
        int          ready_wait;
        int          rsp_delay;
        logic [63:0] data;
        requester_t  first;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        bus.ic_req_valid  = 1'b0;
        bus.ic_req_info   = '0;
        bus.dc_req_valid  = 1'b0;
        bus.dc_req_info   = '0;
        bus.mem_req_ready = 1'b0;
        bus.mem_rsp_valid = 1'b0;
        bus.mem_rsp_data  = '0;
    endtask

    function automatic memory_request_t mk_req(input logic [31:0] addr, input logic st);
        memory_request_t r;
        r.addr     = addr;
        r.is_store = st;
        r.wdata    = {addr, ~addr};
        return r;
    endfunction

    function automatic memory_request_t rand_req();
        memory_request_t r;
        r.addr     = $urandom;
        r.is_store = 1'($urandom_range(0, 1));
        r.wdata    = {$urandom, $urandom};
        return r;
    endfunction

    // Services one memory transaction end to end and checks every visible step of it.
    task automatic serve(input requester_t who, input memory_request_t exp_req, input int ready_wait,
                         input int rsp_delay, input logic [63:0] data);
        int k;
        memory_request_t snap;
        k = 0;
        while (!bus.mem_req_valid && k < 20) begin
            step();
            k++;
        end
        check("grant_latency", k, 0);
        if (!bus.mem_req_valid) return;
        check("req_info", bus.mem_req_info, exp_req);
        check("busy_in_req", bus.arb_busy, 1'b1);
        snap = bus.mem_req_info;
        for (int j = 0; j < ready_wait; j++) begin
            bus.mem_req_ready = 1'b0;
            step();
            check("stall_valid", bus.mem_req_valid, 1'b1);
            check("stall_info", bus.mem_req_info, snap);
        end
        bus.mem_req_ready = 1'b1;
        step();
        bus.mem_req_ready = 1'b0;
        check("valid_drop_after_accept", bus.mem_req_valid, 1'b0);
        for (int j = 0; j < rsp_delay; j++) begin
            check("no_early_rsp", {bus.ic_rsp_valid, bus.dc_rsp_valid}, 2'b00);
            step();
        end
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rsp_data  = data;
        step();
        bus.mem_rsp_valid = 1'b0;
        bus.mem_rsp_data  = ~data;
        check("owner_rsp_valid", (who == ICACHE) ? bus.ic_rsp_valid : bus.dc_rsp_valid, 1'b1);
        check("other_rsp_valid", (who == ICACHE) ? bus.dc_rsp_valid : bus.ic_rsp_valid, 1'b0);
        check("owner_rsp_data", (who == ICACHE) ? bus.ic_rsp_data : bus.dc_rsp_data, data);
        check("idle_after_rsp", bus.arb_busy, 1'b0);
        step();
        check("rsp_one_cycle", (who == ICACHE) ? bus.ic_rsp_valid : bus.dc_rsp_valid, 1'b0);
        check("rsp_data_held", (who == ICACHE) ? bus.ic_rsp_data : bus.dc_rsp_data, data);
    endtask

    // Random-traffic reference model state
    logic            ic_out, dc_out, ic_wait, dc_wait;
    memory_request_t ic_req, dc_req, held;
    requester_t      last_win, owner, win;
    logic            active, mem_acc, exp_rsp, prev_valid, drove_ready;
    int              rsp_cnt, done_tx, k;
    logic [63:0]     exp_dat;

    initial begin
        requester_t tie2;
        memory_request_t icr, dcr;
        tie2 = RR ? ICACHE : DCACHE;
        vecs[0] = '{1'b1, 1'b1, 32'h0000_1100, 32'h0000_2100, 1'b0, 0, 2, 64'h1111_2222_3333_4444, DCACHE};
        vecs[1] = '{1'b0, 1'b1, 32'h0,         32'h0000_2040, 1'b1, 4, 3, 64'h0BAD_F00D_0000_2040, DCACHE};
        vecs[2] = '{1'b1, 1'b1, 32'h0000_1200, 32'h0000_2200, 1'b1, 1, 1, 64'h5555_6666_7777_8888, tie2};
        vecs[3] = '{1'b1, 1'b1, 32'h0000_1300, 32'h0000_2300, 1'b0, 0, 0, 64'h9999_AAAA_BBBB_CCCC, tie2};
        vecs[4] = '{1'b1, 1'b0, 32'h0000_1000, 32'h0,         1'b0, 0, 5, LINE_A5, ICACHE};

        idle_inputs();
        step();
        step();
        check("rst_mem_req_valid", bus.mem_req_valid, 1'b0);
        check("rst_busy", bus.arb_busy, 1'b0);
        check("rst_rsp_valid", {bus.ic_rsp_valid, bus.dc_rsp_valid}, 2'b00);
        check("rst_rsp_data", {bus.ic_rsp_data, bus.dc_rsp_data}, 128'h0);
        check("rst_req_info", bus.mem_req_info, '0);
        reset = 1'b0;
        step();

        for (int i = 0; i < 5; i++) begin
            icr = mk_req(vecs[i].ic_addr, 1'b0);
            dcr = mk_req(vecs[i].dc_addr, vecs[i].dc_store);
            bus.ic_req_valid = vecs[i].ic_v;
            bus.ic_req_info  = icr;
            bus.dc_req_valid = vecs[i].dc_v;
            bus.dc_req_info  = dcr;
            step();
            bus.ic_req_valid = 1'b0;
            bus.dc_req_valid = 1'b0;
            bus.ic_req_info  = '1;
            bus.dc_req_info  = '1;
            serve(vecs[i].first, (vecs[i].first == ICACHE) ? icr : dcr,
                  vecs[i].ready_wait, vecs[i].rsp_delay, vecs[i].data);
            if (vecs[i].ic_v && vecs[i].dc_v) begin
                serve((vecs[i].first == ICACHE) ? DCACHE : ICACHE,
                      (vecs[i].first == ICACHE) ? dcr : icr, 0, 1, ~vecs[i].data);
            end
            step();
            check("quiet_between_vectors", bus.arb_busy, 1'b0);
        end

        // Spurious memory response while idle
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rsp_data  = 64'hDEAD_BEEF_DEAD_BEEF;
        step();
        bus.mem_rsp_valid = 1'b0;
        check("spurious_no_rsp", {bus.ic_rsp_valid, bus.dc_rsp_valid}, 2'b00);
        check("spurious_ic_data_held", bus.ic_rsp_data, LINE_A5);
        step();
        check("spurious_stays_idle", {bus.arb_busy, bus.mem_req_valid}, 2'b00);

        // Reset in WAIT_RSP with a dcache request pending
        bus.ic_req_valid = 1'b1;
        bus.ic_req_info  = mk_req(32'h0000_3000, 1'b0);
        step();
        bus.ic_req_valid = 1'b0;
        check("rst_seq_req", bus.mem_req_valid, 1'b1);
        bus.mem_req_ready = 1'b1;
        step();
        bus.mem_req_ready = 1'b0;
        bus.dc_req_valid  = 1'b1;
        bus.dc_req_info   = mk_req(32'h0000_4000, 1'b1);
        step();
        bus.dc_req_valid = 1'b0;
        check("rst_seq_busy", bus.arb_busy, 1'b1);
        #3 reset = 1'b1;
        #1;
        check("async_rst_outputs", {bus.mem_req_valid, bus.arb_busy, bus.ic_rsp_valid, bus.dc_rsp_valid}, 4'b0);
        check("async_rst_data", {bus.ic_rsp_data, bus.dc_rsp_data}, 128'h0);
        check("async_rst_info", bus.mem_req_info, '0);
        step();
        step();
        reset = 1'b0;
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rsp_data  = 64'h1234_5678_9ABC_DEF0;
        step();
        bus.mem_rsp_valid = 1'b0;
        for (int j = 0; j < 6; j++) begin
            check("post_rst_silent", {bus.ic_rsp_valid, bus.dc_rsp_valid, bus.mem_req_valid, bus.arb_busy}, 4'b0);
            step();
        end

        // Random traffic checked against a transaction-level model
        ic_out = 0; dc_out = 0; ic_wait = 0; dc_wait = 0;
        ic_req = '0; dc_req = '0; held = '0;
        last_win = ICACHE; owner = ICACHE; win = ICACHE;
        active = 0; mem_acc = 0; exp_rsp = 0; prev_valid = 0; drove_ready = 0;
        rsp_cnt = 0; done_tx = 0; exp_dat = '0;
        for (int n = 0; n < 3000; n++) begin
            check("rnd_ic_rsp_valid", bus.ic_rsp_valid, exp_rsp && owner == ICACHE);
            check("rnd_dc_rsp_valid", bus.dc_rsp_valid, exp_rsp && owner == DCACHE);
            if (exp_rsp) begin
                check("rnd_rsp_data", (owner == ICACHE) ? bus.ic_rsp_data : bus.dc_rsp_data, exp_dat);
                if (owner == ICACHE) ic_out = 0; else dc_out = 0;
                active  = 0;
                exp_rsp = 0;
                done_tx++;
            end
            if (prev_valid && drove_ready) begin
                check("rnd_valid_drop", bus.mem_req_valid, 1'b0);
                mem_acc = 1;
                rsp_cnt = $urandom_range(0, 4);
            end else if (prev_valid) begin
                check("rnd_valid_hold", bus.mem_req_valid, 1'b1);
                check("rnd_info_stable", bus.mem_req_info, held);
            end else if (bus.mem_req_valid) begin
                check("rnd_grant_has_request", ic_wait || dc_wait, 1'b1);
                check("rnd_grant_while_free", active, 1'b0);
                if (ic_wait && dc_wait) begin
                    if (RR) win = (last_win == DCACHE) ? ICACHE : DCACHE;
                    else    win = DCACHE;
                end else begin
                    win = dc_wait ? DCACHE : ICACHE;
                end
                check("rnd_grant_info", bus.mem_req_info, (win == DCACHE) ? dc_req : ic_req);
                owner    = win;
                last_win = win;
                active   = 1;
                held     = bus.mem_req_info;
                if (win == DCACHE) dc_wait = 0; else ic_wait = 0;
            end
            check("rnd_busy", bus.arb_busy, active);

            prev_valid        = bus.mem_req_valid;
            drove_ready       = ($urandom_range(0, 2) != 0);
            bus.mem_req_ready = drove_ready;
            bus.mem_rsp_valid = 1'b0;
            bus.mem_rsp_data  = {$urandom, $urandom};
            if (mem_acc) begin
                if (rsp_cnt == 0) begin
                    bus.mem_rsp_valid = 1'b1;
                    exp_rsp = 1;
                    exp_dat = bus.mem_rsp_data;
                    mem_acc = 0;
                end else begin
                    rsp_cnt--;
                end
            end else if ($urandom_range(0, 15) == 0) begin
                bus.mem_rsp_valid = 1'b1;
            end
            bus.ic_req_valid = 1'b0;
            bus.dc_req_valid = 1'b0;
            bus.ic_req_info  = rand_req();
            bus.dc_req_info  = rand_req();
            if (!ic_out && $urandom_range(0, 3) == 0) begin
                ic_req = rand_req();
                bus.ic_req_valid = 1'b1;
                bus.ic_req_info  = ic_req;
                ic_out = 1;
                ic_wait = 1;
            end
            if (!dc_out && $urandom_range(0, 3) == 0) begin
                dc_req = rand_req();
                bus.dc_req_valid = 1'b1;
                bus.dc_req_info  = dc_req;
                dc_out = 1;
                dc_wait = 1;
            end
            step();
        end
        k = done_tx;
        check("rnd_progress", k > 100, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
